// File: rtl/tx_gearbox_pkg.sv
// Shared types and constants for the 10GBASE-R TX gearbox (66b blocks -> 32b line words).
package tx_gearbox_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned HDR_WIDTH  = 2;
  localparam int unsigned BLOCK_SIZE = 66;
  localparam int unsigned SEQ_MAX    = 32;
  localparam int unsigned SEQ_WIDTH  = 6;
  localparam int unsigned BUF_WIDTH  = 64;

  // One encoded block as handed over by the encoder; also used by the RX sync bench.
  typedef struct packed {
    logic [HDR_WIDTH-1:0]       sync_hdr;
    logic [1:0][DATA_WIDTH-1:0] data_word;
  } encoded_block_t;

  // Residual bits held before the beat at a given seq: seq rounded up to even.
  function automatic logic [SEQ_WIDTH-1:0] residual_bits(input logic [SEQ_WIDTH-1:0] seq);
    return seq + {{(SEQ_WIDTH-1){1'b0}}, seq[0]};
  endfunction

endpackage

// File: rtl/gearbox_seq_ctrl.sv
// Beat sequencer for the TX gearbox: 33-slot cycle of 32 beats plus one pause slot.
module gearbox_seq_ctrl
  import tx_gearbox_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid,
  output logic [SEQ_WIDTH-1:0] seq,
  output logic                 ready,
  output logic                 first_beat,
  output logic                 advance
);

  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 pause;

  // Decode slot type and next sequence value.
  always_comb begin
    pause      = (seq_q == SEQ_WIDTH'(SEQ_MAX));
    ready      = !pause;
    first_beat = !seq_q[0] && !pause;
    // The pause slot always advances, independent of the encoder.
    advance    = (data_valid && ready) || pause;
    seq_d      = seq_q;
    if (pause) begin
      seq_d = '0;
    end else if (advance) begin
      seq_d = seq_q + SEQ_WIDTH'(1);
    end
  end

  // Sequence register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq = seq_q;

endmodule

// File: rtl/tx_gearbox_66b32b.sv
// TX gearbox: packs {hdr, word0, word1} blocks LSB-first into a continuous 32-bit stream.
// Optional sticky error flag built when GEARBOX_ERR_CHECK_EN is defined.
module tx_gearbox_66b32b
  import tx_gearbox_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_err
);

  logic [SEQ_WIDTH-1:0]  seq;
  logic                  first_beat;
  logic                  advance;
  logic [SEQ_WIDTH-1:0]  res_cnt;
  logic [BUF_WIDTH-1:0]  buf_q, buf_d;
  logic [BUF_WIDTH-1:0]  new_bits;
  logic [BUF_WIDTH-1:0]  combined;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  gearbox_seq_ctrl u_seq_ctrl (
    .clk        (i_clk),
    .reset      (i_reset),
    .data_valid (i_data_valid),
    .seq        (seq),
    .ready      (o_ready),
    .first_beat (first_beat),
    .advance    (advance)
  );

  // Merge incoming bits above the residual; low 32 bits go out, the rest is kept.
  always_comb begin
    res_cnt  = residual_bits(seq);
    new_bits = '0;
    if (o_ready) begin
      if (first_beat) begin
        new_bits = {{(BUF_WIDTH-DATA_WIDTH-HDR_WIDTH){1'b0}}, i_data, i_hdr};
      end else begin
        new_bits = {{(BUF_WIDTH-DATA_WIDTH){1'b0}}, i_data};
      end
    end
    combined = buf_q | (new_bits << res_cnt);
    buf_d    = buf_q;
    if (advance) begin
      buf_d = combined >> DATA_WIDTH;
    end
  end

  // Residual buffer and registered line output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      valid_q <= advance;
      if (advance) begin
        data_q <= combined[DATA_WIDTH-1:0];
      end
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;

`ifdef GEARBOX_ERR_CHECK_EN
  logic err_q;
  logic bad_hdr;
  logic pause_valid;

  // Flag illegal sync headers and encoder offers during the pause slot.
  always_comb begin
    bad_hdr     = i_data_valid && first_beat && ((i_hdr == 2'b00) || (i_hdr == 2'b11));
    pause_valid = i_data_valid && !o_ready;
  end

  // Sticky until reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad_hdr | pause_valid;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/tx_gearbox_66b32b.md
Name: tx_gearbox_66b32b

Overview:
- TX-side gearbox for the 10GBASE-R PCS. Converts 66-bit encoded blocks into a continuous 32-bit stream for the serializer/PMA. It is the mirror of the RX block sync.
- Input per block: 2-bit sync header plus two 32-bit data words, supplied as two accepted 32-bit beats.
- Output: one 32-bit word per cycle with header bits packed in-line.
- Backpressures the encoder for one cycle in every 33 to absorb the 2-bit/block header overhead (16 blocks × 66 = 1056 = 33 × 32).

Parameters:
- DATA_WIDTH, 32, input/output word width; only 32 is supported.
- HDR_WIDTH, 2, sync header width.
- BLOCK_SIZE, 66, encoded block length.

Ports:
- i_clk  input  1  core clock.
- i_reset  input  1  reset; asynchronous, active-high.
- i_data  input  32  data word; first beat of a block = data_word[0], second beat = data_word[1].
- i_hdr  input  2  sync header; sampled only on the first beat of a block.
- i_data_valid  input  1  beat offered by the encoder.
- o_ready  output  1  gearbox accepts a beat this cycle; low during the pause slot.
- o_data  output  32  gearbox output word; bit 0 is transmitted first.
- o_data_valid  output  1  o_data holds a valid line word.
- o_err  output  1  sticky error flag (only when GEARBOX_ERR_CHECK_EN is defined; tied 0 otherwise).

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-high.
- Block bit order on the line, LSB first: hdr[0], hdr[1], data_word[0][0..31], data_word[1][0..31]. This matches the RX sync stream order.
- Handshake: a beat transfers when i_data_valid && o_ready.
  - i_data_valid with o_ready low: the beat is not consumed; the source must hold it.
  - No transfer while o_ready is high: sequence state holds, o_data_valid = 0 next cycle, no bits are emitted.
- Sequence counter seq, 0..32, advances only on a transfer or on the pause slot.
  - o_ready = (seq != 32), combinational from seq.
  - seq even (0..30): beat is the first word of a block; buffer appends {i_data, i_hdr} (34 bits).
  - seq odd (1..31): buffer appends i_data (32 bits).
  - seq == 32 (pause): nothing is appended; the 32 residual bits are emitted; seq wraps to 0 unconditionally. The pause does not depend on i_data_valid.
- Residual buffer: 64-bit register, residual count r.
  - Each advancing cycle emits the lowest 32 bits of {new bits, residual}, then shifts.
  - r = 2k after block k. r = 32 before the pause, r = 0 after it. Maximum occupancy is 30 + 34 = 64 bits.
  - r, and the buffer bit range, are fully determined by seq.
- Latency: o_data and o_data_valid are registered, 1 cycle after the accepting/pause edge.
- Reset values: o_data = 0, o_data_valid = 0, o_err = 0, seq = 0, buffer = 0. o_ready = 1 after reset.
- Reset mid-operation: any partial block is discarded; the next accepted beat is treated as a block start with a header.
- The encoder owns block alignment. The gearbox never resynchronizes on its own.

Optional Feature:
- Macro: GEARBOX_ERR_CHECK_EN.
- Defined: o_err is set and stays set (cleared only by reset) on either of:
  - a first-beat header of 2'b00 or 2'b11;
  - i_data_valid asserted while seq == 32.
- o_err is registered, asserted 1 cycle after the offending edge. The data path is unaffected.
- Undefined: no checking logic is built; o_err is driven constant 0.

Decomposition:
- Shared package tx_gearbox_pkg:
  - DATA_WIDTH, HDR_WIDTH, BLOCK_SIZE.
  - SEQ_MAX = 32.
  - encoded_block_t struct {sync_hdr, data_word[1:0]}, shared with the RX sync bench.
- Sub-module: gearbox_seq_ctrl (seq counter, o_ready, first-beat flag). The shift/pack datapath stays in the top module.

Test Plan:
- Reset release -> o_ready = 1, o_data_valid = 0, o_data = 0. Then beats hdr = 2'b01, data_word[0] = 32'hDEADBEEF -> next cycle o_data = 32'h7AB6FBBD (= {DEADBEEF[29:0], 2'b01}), o_data_valid = 1.
- 16 back-to-back random blocks (32 beats) -> o_ready low exactly at cycle 33. The 33rd output word equals data_word[1][31:0] of block 16 shifted by 32 residual. The bit stream concatenated LSB-first equals the reference 1056-bit stream.
- Continuous random traffic over 10 000 blocks, fed to the RX block sync model -> lock achieved, 0 header/data mismatches. o_ready duty cycle is exactly 32/33.
- i_data_valid deasserted for 3 cycles mid-block (after first beat) -> o_data_valid low for 3 cycles, seq frozen, stream resumes bit-exact with no dropped or duplicated bits.
- Assert i_reset at seq = 17 for 2 cycles -> all outputs return to reset values asynchronously; first post-reset beat emits its header in o_data[1:0].
- GEARBOX_ERR_CHECK_EN defined: hdr = 2'b11 on a first beat, or i_data_valid at seq = 32 -> o_err = 1 next cycle, held until reset. Same stimulus with the macro undefined -> o_err = 0.
